// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
// Frame states, parity modes and stop-bit selections.
package uart_pkg;

    localparam int MIN_WLEN = 5;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_ODD   = 3'd1,
        PAR_EVEN  = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } par_mode_t;

    typedef enum logic [1:0] {
        STOP_ONE      = 2'b00,
        STOP_ONE_HALF = 2'b01,
        STOP_TWO      = 2'b10
    } stop_sel_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX holding FIFO with flush.
// A flush wins over a push issued in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == CW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + CW'(1);
                2'b01:   level <= level - CW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr && !rst) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_gen.sv
// UART transmitter: frame engine, parity, output register and TX FIFO.
// Frame settings are captured when a word is loaded and held to its end.
module uart_tx_gen
    import uart_pkg::*;
#(
    parameter int MAX_DATA_W = 8,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 16,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_pulse,
    input  logic                  wr_valid,
    input  logic [MAX_DATA_W-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  fifo_clr,
    input  logic [2:0]            wlen,
    input  logic [2:0]            par_mode,
    input  logic [1:0]            stop_sel,
    input  logic                  msb_first,
    input  logic                  set_break,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  sreg_empty,
    output logic [CNT_W-1:0]      fifo_level
);

    localparam int TW = $clog2(2 * OVS);
    localparam int BW = $clog2(MAX_DATA_W + 1);
    localparam logic [TW-1:0] T_BIT      = TW'(OVS - 1);
    localparam logic [TW-1:0] T_ONE_HALF = TW'(3 * OVS / 2 - 1);
    localparam logic [TW-1:0] T_TWO      = TW'(2 * OVS - 1);
    localparam logic [2:0]    WLEN_MAX   = 3'(MAX_DATA_W - MIN_WLEN);

    tx_state_t             state, state_nxt;
    logic [TW-1:0]         tick, tick_nxt;
    logic [BW-1:0]         left, left_nxt;
    logic [MAX_DATA_W-1:0] sr, sr_nxt;
    logic                  par_en, par_en_nxt;
    logic                  par_bit, par_bit_nxt;
    logic [TW-1:0]         stop_len, stop_len_nxt;
    logic                  tx_data, tx_data_nxt;

    logic                  load;
    logic                  empty;
    logic                  full;
    logic [MAX_DATA_W-1:0] head;

    logic [BW-1:0]         in_nbits;
    logic [MAX_DATA_W-1:0] in_word;
    logic [MAX_DATA_W-1:0] in_rev;
    logic [MAX_DATA_W-1:0] in_load;
    logic                  in_par_en;
    logic                  in_par_bit;
    logic [TW-1:0]         in_stop_len;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MAX_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_valid),
        .pop   (load),
        .clr   (fifo_clr),
        .wdata (wr_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign wr_ready   = !full;
    assign tx_busy    = (state != IDLE);
    assign sreg_empty = (state == IDLE) && empty;

    // MSB-first words are reversed at load so the shifter always emits sr[0].
    always_comb begin
        if (wlen > WLEN_MAX) begin
            in_nbits = BW'(MAX_DATA_W);
        end else begin
            in_nbits = BW'(MIN_WLEN) + BW'(wlen);
        end
        in_word = head & ~({MAX_DATA_W{1'b1}} << in_nbits);
        in_rev  = '0;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            in_rev[i] = in_word[MAX_DATA_W-1-i];
        end
        if (msb_first) begin
            in_load = in_rev >> (BW'(MAX_DATA_W) - in_nbits);
        end else begin
            in_load = in_word;
        end

        in_par_en  = 1'b1;
        in_par_bit = 1'b0;
        unique case (par_mode_t'(par_mode))
            PAR_ODD:   in_par_bit = ~^in_word;
            PAR_EVEN:  in_par_bit = ^in_word;
            PAR_MARK:  in_par_bit = 1'b1;
            PAR_SPACE: in_par_bit = 1'b0;
            default:   in_par_en  = 1'b0;
        endcase

        unique case (stop_sel_t'(stop_sel))
            STOP_ONE:      in_stop_len = T_BIT;
            STOP_ONE_HALF: in_stop_len = T_ONE_HALF;
            default:       in_stop_len = T_TWO;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        tick_nxt     = tick;
        left_nxt     = left;
        sr_nxt       = sr;
        par_en_nxt   = par_en;
        par_bit_nxt  = par_bit;
        stop_len_nxt = stop_len;
        tx_data_nxt  = tx_data;
        load         = 1'b0;

        if (baud_pulse) begin
            unique case (state)
                IDLE: begin
                    load = !empty;
                end
                START: begin
                    if (tick == '0) begin
                        state_nxt   = DATA;
                        tick_nxt    = T_BIT;
                        tx_data_nxt = sr[0];
                    end else begin
                        tick_nxt = tick - TW'(1);
                    end
                end
                DATA: begin
                    if (tick == '0) begin
                        tick_nxt = T_BIT;
                        if (left != '0) begin
                            sr_nxt      = sr >> 1;
                            left_nxt    = left - BW'(1);
                            tx_data_nxt = sr[1];
                        end else if (par_en) begin
                            state_nxt   = PARITY;
                            tx_data_nxt = par_bit;
                        end else begin
                            state_nxt   = STOP;
                            tick_nxt    = stop_len;
                            tx_data_nxt = 1'b1;
                        end
                    end else begin
                        tick_nxt = tick - TW'(1);
                    end
                end
                PARITY: begin
                    if (tick == '0) begin
                        state_nxt   = STOP;
                        tick_nxt    = stop_len;
                        tx_data_nxt = 1'b1;
                    end else begin
                        tick_nxt = tick - TW'(1);
                    end
                end
                STOP: begin
                    if (tick != '0) begin
                        tick_nxt = tick - TW'(1);
                    end else if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        tick_nxt  = T_BIT;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        if (load) begin
            state_nxt    = START;
            tick_nxt     = T_BIT;
            left_nxt     = in_nbits - BW'(1);
            sr_nxt       = in_load;
            par_en_nxt   = in_par_en;
            par_bit_nxt  = in_par_bit;
            stop_len_nxt = in_stop_len;
            tx_data_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick     <= T_BIT;
            left     <= '0;
            sr       <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            stop_len <= T_BIT;
            tx_data  <= 1'b1;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            tick     <= tick_nxt;
            left     <= left_nxt;
            sr       <= sr_nxt;
            par_en   <= par_en_nxt;
            par_bit  <= par_bit_nxt;
            stop_len <= stop_len_nxt;
            tx_data  <= tx_data_nxt;
            tx       <= tx_data & ~set_break;
        end
    end

endmodule
